// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes,
// ALU operation classes, ALU control codes and datapath mux selects.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // Immediate format depends only on the opcode, never on the FSM state.
   function automatic logic [1:0] imm_src_of(input logic [6:0] op);
      case (op)
         OP_SW:   imm_src_of = IMM_S;
         OP_BEQ:  imm_src_of = IMM_B;
         OP_JAL:  imm_src_of = IMM_J;
         default: imm_src_of = IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps the FSM's ALU operation class and the
// instruction function fields onto the ALU control code.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  aluop_t      aluop,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   input  logic        op5,
   output logic [2:0]  alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (aluop)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // op5 separates R-type from I-type: addi has no subtract form.
               3'b000:  alu_control = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences the shared ALU, the unified memory
// port and the register file for lw, sw, R/I-type ALU, beq and jal.
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter bit MEM_HANDSHAKE = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  op,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        adr_src,
   output logic        mem_write,
   output logic        ir_write,
   output logic        pc_write,
   output logic        reg_write,
   output logic [1:0]  result_src,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  imm_src,
   output logic [2:0]  alu_control,
   output logic        instr_done,
   output logic        illegal_op,
   output logic [3:0]  state_o
);

   // Memory handshake: mem_req is held (with address and mem_write stable)
   // for every cycle of a memory state; the access completes in the cycle
   // mem_ready is high, and only then does the FSM leave that state.
   state_t state, next_state;
   logic   rdy;
   aluop_t aluop;
   logic   mem_req_raw, mem_write_raw, ir_write_raw, reg_write_raw;
   logic   pc_update, branch, done_raw;

   assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_FETCH;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_op <= 1'b0;
      end else if (state == S_DECODE && next_state == S_TRAP) begin
         illegal_op <= 1'b1;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_FETCH:    if (rdy) next_state = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: next_state = S_MEMADR;
               OP_R:         next_state = S_EXECR;
               OP_I:         next_state = S_EXECI;
               OP_JAL:       next_state = S_JAL;
               OP_BEQ:       next_state = S_BEQ;
               default:      next_state = S_TRAP;
            endcase
         end
         S_MEMADR:   next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (rdy) next_state = S_MEMWB;
         S_MEMWB:    next_state = S_FETCH;
         S_MEMWRITE: if (rdy) next_state = S_FETCH;
         S_EXECR:    next_state = S_ALUWB;
         S_EXECI:    next_state = S_ALUWB;
         S_ALUWB:    next_state = S_FETCH;
         S_JAL:      next_state = S_ALUWB;
         S_BEQ:      next_state = S_FETCH;
         S_TRAP:     next_state = S_TRAP;
         default:    next_state = S_FETCH;
      endcase
   end

   always_comb begin
      mem_req_raw   = 1'b0;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      pc_update     = 1'b0;
      branch        = 1'b0;
      done_raw      = 1'b0;
      adr_src       = 1'b0;
      result_src    = RES_ALUOUT;
      alu_src_a     = SRCA_PC;
      alu_src_b     = SRCB_RS2;
      aluop         = ALUOP_ADD;
      case (state)
         S_FETCH: begin
            mem_req_raw  = 1'b1;
            alu_src_b    = SRCB_FOUR;
            result_src   = RES_ALU;
            ir_write_raw = rdy;
            pc_update    = rdy;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
         end
         S_MEMREAD: begin
            mem_req_raw = 1'b1;
            adr_src     = 1'b1;
         end
         S_MEMWB: begin
            result_src    = RES_DATA;
            reg_write_raw = 1'b1;
            done_raw      = 1'b1;
         end
         S_MEMWRITE: begin
            mem_req_raw   = 1'b1;
            adr_src       = 1'b1;
            mem_write_raw = 1'b1;
            done_raw      = rdy;
         end
         S_EXECR: begin
            alu_src_a = SRCA_RS1;
            aluop     = ALUOP_FUNCT;
         end
         S_EXECI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            aluop     = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            reg_write_raw = 1'b1;
            done_raw      = 1'b1;
         end
         S_JAL: begin
            // PC takes the target from ALUOut while the ALU forms the link value.
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pc_update = 1'b1;
         end
         S_BEQ: begin
            alu_src_a = SRCA_RS1;
            aluop     = ALUOP_SUB;
            branch    = 1'b1;
            done_raw  = 1'b1;
         end
         default: ;
      endcase
   end

   // Reset masks every write strobe so an abandoned instruction leaves no trace.
   assign mem_req    = rst_n & mem_req_raw;
   assign mem_write  = rst_n & mem_write_raw;
   assign ir_write   = rst_n & ir_write_raw;
   assign reg_write  = rst_n & reg_write_raw;
   assign pc_write   = rst_n & (pc_update | (branch & zero));
   assign instr_done = rst_n & done_raw;
   assign imm_src    = imm_src_of(op);
   assign state_o    = state;

   alu_decoder u_alu_decoder (
      .aluop       (aluop),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .op5         (op[5]),
      .alu_control (alu_control)
   );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed plus randomized bench for multicycle_controller, checked against an
// instruction-level model of the state sequence and control strobes.
module tb_multicycle_controller;

   localparam logic [6:0] T_LW   = 7'b0000011;
   localparam logic [6:0] T_SW   = 7'b0100011;
   localparam logic [6:0] T_R    = 7'b0110011;
   localparam logic [6:0] T_I    = 7'b0010011;
   localparam logic [6:0] T_JAL  = 7'b1101111;
   localparam logic [6:0] T_BEQ  = 7'b1100011;
   localparam logic [6:0] T_BAD  = 7'b1111111;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, adr_src, mem_write, ir_write, pc_write, reg_write;
   logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0] alu_control;
   logic       instr_done, illegal_op;
   logic [3:0] state_o;

   int vectors = 0;
   int miscompares = 0;

   multicycle_controller #(.MEM_HANDSHAKE(1'b1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .op          (op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .zero        (zero),
      .mem_ready   (mem_ready),
      .mem_req     (mem_req),
      .adr_src     (adr_src),
      .mem_write   (mem_write),
      .ir_write    (ir_write),
      .pc_write    (pc_write),
      .reg_write   (reg_write),
      .result_src  (result_src),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .imm_src     (imm_src),
      .alu_control (alu_control),
      .instr_done  (instr_done),
      .illegal_op  (illegal_op),
      .state_o     (state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ALU operation the instruction asks for in its execute cycle.
   function automatic logic [2:0] want_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
      case (f3)
         3'b000:  want_alu = (o == T_R && f7) ? 3'b001 : 3'b000;
         3'b010:  want_alu = 3'b101;
         3'b110:  want_alu = 3'b011;
         3'b111:  want_alu = 3'b010;
         default: want_alu = 3'b000;
      endcase
   endfunction

   function automatic logic [1:0] want_imm(input logic [6:0] o);
      if (o == T_SW) want_imm = 2'b01;
      else if (o == T_BEQ) want_imm = 2'b10;
      else if (o == T_JAL) want_imm = 2'b11;
      else want_imm = 2'b00;
   endfunction

   // zero_mode: 0 forces zero low, 1 forces high, 2 randomizes it.
   task automatic run_instr(input logic [6:0] op_i, input logic [2:0] f3_i, input logic f7_i,
                            input int fetch_stalls, input int stall_pct, input int zero_mode);
      int q[$];
      int i, guard, stalls, s;
      logic rdy, mem_st, last;
      logic [2:0] exp_alu;
      op = op_i; funct3 = f3_i; funct7b5 = f7_i;
      q = '{0, 1};
      case (op_i)
         T_LW:    begin q.push_back(2); q.push_back(3); q.push_back(4); end
         T_SW:    begin q.push_back(2); q.push_back(5); end
         T_R:     begin q.push_back(6); q.push_back(7); end
         T_I:     begin q.push_back(8); q.push_back(7); end
         T_JAL:   begin q.push_back(9); q.push_back(7); end
         T_BEQ:   q.push_back(10);
         default: for (int k = 0; k < 11; k++) q.push_back(11);
      endcase
      i = 0; guard = 0; stalls = fetch_stalls;
      while (i < q.size() && guard < 300) begin
         s = q[i];
         mem_st = (s == 0 || s == 3 || s == 5);
         if (s == 0 && stalls > 0) begin
            rdy = 1'b0;
            stalls--;
         end else begin
            rdy = ($urandom_range(0, 99) >= stall_pct);
         end
         mem_ready = rdy;
         zero = (zero_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(zero_mode);
         last = (i == q.size() - 1);
         exp_alu = (s == 6 || s == 8) ? want_alu(op_i, f3_i, f7_i) : (s == 10) ? 3'b001 : 3'b000;
         @(negedge clk);
         chk("state", 8'(state_o), 8'(s));
         chk("mem_req", 8'(mem_req), 8'(mem_st));
         chk("adr_src", 8'(adr_src), 8'(s == 3 || s == 5));
         chk("ir_write", 8'(ir_write), 8'(s == 0 && rdy));
         chk("pc_write", 8'(pc_write), 8'((s == 0 && rdy) || s == 9 || (s == 10 && zero)));
         chk("reg_write", 8'(reg_write), 8'(s == 4 || s == 7));
         chk("mem_write", 8'(mem_write), 8'(s == 5));
         chk("instr_done", 8'(instr_done), 8'(last && s != 11 && (s != 5 || rdy)));
         chk("result_src", 8'(result_src), (s == 0) ? 8'd2 : (s == 4) ? 8'd1 : 8'd0);
         chk("alu_control", 8'(alu_control), 8'(exp_alu));
         chk("imm_src", 8'(imm_src), 8'(want_imm(op_i)));
         chk("illegal_op", 8'(illegal_op), 8'(s == 11));
         @(posedge clk); #1;
         if (!(mem_st && !rdy)) i++;
         guard++;
      end
      if (i < q.size()) begin
         vectors++;
         miscompares++;
         $error("FAIL timeout observed_step=%0d expected_steps=%0d", i, q.size());
      end
   endtask

   task automatic reset_check(input string tag);
      chk({tag, "_state"}, 8'(state_o), 8'd0);
      chk({tag, "_illegal"}, 8'(illegal_op), 8'd0);
      chk({tag, "_strobes"}, {2'b00, pc_write, ir_write, reg_write, mem_write, mem_req, instr_done}, 8'd0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      mem_ready = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [6:0] ops[6];
      ops = '{T_LW, T_SW, T_R, T_I, T_JAL, T_BEQ};
      rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1;
      op = T_LW; funct3 = 3'b000; funct7b5 = 1'b0;
      #3;
      reset_check("reset");
      repeat (2) @(posedge clk);
      release_reset();

      run_instr(T_LW, 3'b010, 1'b0, 0, 0, 2);
      run_instr(T_R, 3'b000, 1'b1, 3, 0, 2);
      run_instr(T_R, 3'b000, 1'b1, 0, 0, 2);
      run_instr(T_I, 3'b000, 1'b1, 0, 0, 2);
      run_instr(T_R, 3'b110, 1'b0, 0, 0, 2);
      run_instr(T_BEQ, 3'b000, 1'b0, 0, 0, 1);
      run_instr(T_BEQ, 3'b000, 1'b0, 0, 0, 0);
      run_instr(T_JAL, 3'b000, 1'b0, 0, 0, 2);
      run_instr(T_SW, 3'b010, 1'b0, 0, 50, 2);

      for (int n = 0; n < 80; n++) begin
         run_instr(ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2), 30, 2);
      end

      // Illegal opcode parks in TRAP until reset.
      run_instr(T_BAD, 3'b000, 1'b0, 0, 0, 2);
      #2 rst_n = 1'b0;
      #1 reset_check("trap_reset");
      release_reset();

      // Abandon a load in MEMREAD with an asynchronous reset.
      op = T_LW; funct3 = 3'b010; funct7b5 = 1'b0; mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 mem_ready = 1'b0;
      @(negedge clk);
      chk("pre_reset_state", 8'(state_o), 8'd3);
      #2 rst_n = 1'b0; mem_ready = 1'b1;
      #1 reset_check("async_reset");
      @(posedge clk); #1;
      reset_check("held_reset");
      release_reset();
      run_instr(T_LW, 3'b010, 1'b0, 0, 20, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
